// File: rtl/shape_pkg.sv
// Shared definitions for the shape point streamer.
//   shape_e     : shape selector carried on cmd_shape.
//   CODE_BURST  : cmd_code value that turns a line command into an NPTS-point burst.
//   CIRCLE_PTS  : points emitted for an 8-way circle.
//   ELLIPSE_PTS : points emitted for a 4-way ellipse.
//   state_e     : streamer FSM states.
package shape_pkg;

  typedef enum logic [1:0] {
    LINE_X  = 2'b00,
    LINE_Y  = 2'b01,
    CIRCLE  = 2'b10,
    ELLIPSE = 2'b11
  } shape_e;

  localparam logic [3:0] CODE_BURST  = 4'b0101;
  localparam int         CIRCLE_PTS  = 8;
  localparam int         ELLIPSE_PTS = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/shape_point_calc.sv
// Combinational point generator for one beat of a shape command.
// Optional build macro: SHAPE_STREAM_CLIP_EN (clamp results to [0,XMAX]/[0,YMAX];
// otherwise results wrap modulo 2^N).
// Ports:
//   shape          : latched shape selector
//   a, c, ex, bx   : latched operands (N bits)
//   acc            : line step accumulator (N+IW bits, never clamped)
//   idx            : point index within the command
//   x, y           : point coordinates (N bits)
module shape_point_calc
  import shape_pkg::*;
#(
  parameter int N    = 10,
  parameter int IW   = 3,
  parameter int XMAX = 639,
  parameter int YMAX = 479
) (
  input  shape_e          shape,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    c,
  input  logic [N-1:0]    ex,
  input  logic [N-1:0]    bx,
  input  logic [N+IW-1:0] acc,
  input  logic [IW-1:0]   idx,
  output logic [N-1:0]    x,
  output logic [N-1:0]    y
);

  // Wide enough for c*acc+ex without overflow, plus a sign bit for borrows.
  localparam int W = 2*N + IW + 2;

`ifdef SHAPE_STREAM_CLIP_EN
  localparam logic signed [W-1:0] XLIM = W'(XMAX);
  localparam logic signed [W-1:0] YLIM = W'(YMAX);

  function automatic logic [N-1:0] clamp(input logic signed [W-1:0] v,
                                         input logic signed [W-1:0] lim);
    logic [N-1:0] r;
    if (v[W-1]) begin
      r = {N{1'b0}};
    end else if (v > lim) begin
      r = lim[N-1:0];
    end else begin
      r = v[N-1:0];
    end
    return r;
  endfunction
`endif

  logic signed [W-1:0] a_w_s, c_w_s, ex_w_s, bx_w_s, acc_w_s;
  logic signed [W-1:0] lin_s, d1_s, d2_s, rx_s, ry_s;

  // Full-width point arithmetic followed by the wrap/clamp stage.
  always_comb begin
    a_w_s   = {{(W-N){1'b0}}, a};
    c_w_s   = {{(W-N){1'b0}}, c};
    ex_w_s  = {{(W-N){1'b0}}, ex};
    bx_w_s  = {{(W-N){1'b0}}, bx};
    acc_w_s = {{(W-N-IW){1'b0}}, acc};
    lin_s   = c_w_s * acc_w_s + ex_w_s;
    // Index bit 2 swaps the offsets; bit 0 negates x, bit 1 negates y.
    d1_s    = idx[2] ? bx_w_s : c_w_s;
    d2_s    = idx[2] ? c_w_s  : bx_w_s;
    rx_s    = {W{1'b0}};
    ry_s    = {W{1'b0}};
    case (shape)
      LINE_X: begin
        rx_s = acc_w_s;
        ry_s = lin_s;
      end
      LINE_Y: begin
        rx_s = lin_s;
        ry_s = acc_w_s;
      end
      CIRCLE, ELLIPSE: begin
        rx_s = idx[0] ? (a_w_s - d1_s)  : (a_w_s + d1_s);
        ry_s = idx[1] ? (ex_w_s - d2_s) : (ex_w_s + d2_s);
      end
      default: begin
        rx_s = {W{1'b0}};
        ry_s = {W{1'b0}};
      end
    endcase
`ifdef SHAPE_STREAM_CLIP_EN
    x = clamp(rx_s, XLIM);
    y = clamp(ry_s, YLIM);
`else
    x = rx_s[N-1:0];
    y = ry_s[N-1:0];
`endif
  end

endmodule

// File: rtl/shape_point_stream.sv
// Shape point streamer: accepts one shape command over a valid/ready handshake
// and streams its points one per cycle as (x,y) beats with index and last flag.
// Optional build macro: SHAPE_STREAM_CLIP_EN (coordinate clamping, see
// shape_point_calc). Ports and timing are identical in both builds.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_shape, cmd_code           : shape selector, mode (CODE_BURST = burst line)
//   cmd_a, cmd_c, cmd_ex, cmd_bx  : operands
//   pt_valid/pt_ready             : point beat handshake
//   pt_x, pt_y, pt_idx, pt_last   : beat payload (zero when pt_valid is low)
//   busy                          : command in progress
module shape_point_stream
  import shape_pkg::*;
#(
  parameter int N    = 10,
  parameter int NPTS = 8,
  parameter int XMAX = 639,
  parameter int YMAX = 479,
  localparam int IW  = $clog2((NPTS > CIRCLE_PTS) ? NPTS : CIRCLE_PTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_shape,
  input  logic [3:0]    cmd_code,
  input  logic [N-1:0]  cmd_a,
  input  logic [N-1:0]  cmd_c,
  input  logic [N-1:0]  cmd_ex,
  input  logic [N-1:0]  cmd_bx,
  output logic          pt_valid,
  input  logic          pt_ready,
  output logic [N-1:0]  pt_x,
  output logic [N-1:0]  pt_y,
  output logic [IW-1:0] pt_idx,
  output logic          pt_last,
  output logic          busy
);

  state_e          state_q, state_d;
  shape_e          shape_q, shape_d;
  logic [N-1:0]    a_q, a_d, c_q, c_d, ex_q, ex_d, bx_q, bx_d;
  logic [N+IW-1:0] acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  // Index of the final point; stored instead of the count so NPTS fits in IW bits.
  logic [IW-1:0]   last_q, last_d;
  logic [N-1:0]    calc_x_s, calc_y_s;
  logic            emit_s, at_last_s;

  // Handshake and beat qualifiers derived from registered state.
  always_comb begin
    emit_s    = (state_q == ST_EMIT);
    at_last_s = (idx_q == last_q);
    cmd_ready = (state_q == ST_IDLE) && !rst;
    pt_valid  = emit_s;
    busy      = emit_s;
    pt_last   = emit_s && at_last_s;
    pt_idx    = emit_s ? idx_q : {IW{1'b0}};
    pt_x      = emit_s ? calc_x_s : {N{1'b0}};
    pt_y      = emit_s ? calc_y_s : {N{1'b0}};
  end

  // Next-state logic: command latch in IDLE, beat stepping in EMIT.
  always_comb begin
    state_d = state_q;
    shape_d = shape_q;
    a_d     = a_q;
    c_d     = c_q;
    ex_d    = ex_q;
    bx_d    = bx_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          shape_d = shape_e'(cmd_shape);
          a_d     = cmd_a;
          c_d     = cmd_c;
          ex_d    = cmd_ex;
          bx_d    = cmd_bx;
          acc_d   = {{IW{1'b0}}, cmd_a};
          idx_d   = {IW{1'b0}};
          state_d = ST_EMIT;
          case (shape_e'(cmd_shape))
            LINE_X, LINE_Y: last_d = (cmd_code == CODE_BURST) ? IW'(NPTS - 1) : {IW{1'b0}};
            CIRCLE:         last_d = IW'(CIRCLE_PTS - 1);
            ELLIPSE:        last_d = IW'(ELLIPSE_PTS - 1);
            default:        last_d = {IW{1'b0}};
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (pt_ready) begin
          if (at_last_s) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
            acc_d = acc_q + {{IW{1'b0}}, bx_q};
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shape_q <= LINE_X;
      a_q     <= {N{1'b0}};
      c_q     <= {N{1'b0}};
      ex_q    <= {N{1'b0}};
      bx_q    <= {N{1'b0}};
      acc_q   <= {(N+IW){1'b0}};
      idx_q   <= {IW{1'b0}};
      last_q  <= {IW{1'b0}};
    end else begin
      state_q <= state_d;
      shape_q <= shape_d;
      a_q     <= a_d;
      c_q     <= c_d;
      ex_q    <= ex_d;
      bx_q    <= bx_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  shape_point_calc #(
    .N    (N),
    .IW   (IW),
    .XMAX (XMAX),
    .YMAX (YMAX)
  ) u_calc (
    .shape (shape_q),
    .a     (a_q),
    .c     (c_q),
    .ex    (ex_q),
    .bx    (bx_q),
    .acc   (acc_q),
    .idx   (idx_q),
    .x     (calc_x_s),
    .y     (calc_y_s)
  );

endmodule

// File: tb/tb_shape_point_stream.sv
module tb_shape_point_stream;

  localparam int N    = 10;
  localparam int NPTS = 8;
  localparam int IW   = 3;
  localparam int XMAX = 639;
  localparam int YMAX = 479;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_shape;
  logic [3:0]    cmd_code;
  logic [N-1:0]  cmd_a, cmd_c, cmd_ex, cmd_bx;
  logic          pt_valid, pt_ready;
  logic [N-1:0]  pt_x, pt_y;
  logic [IW-1:0] pt_idx;
  logic          pt_last, busy;

  int checks = 0;
  int errors = 0;
  int ex_x[$];
  int ex_y[$];

  always #5 clk = ~clk;

  shape_point_stream #(.N(N), .NPTS(NPTS), .XMAX(XMAX), .YMAX(YMAX)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shape(cmd_shape), .cmd_code(cmd_code),
    .cmd_a(cmd_a), .cmd_c(cmd_c), .cmd_ex(cmd_ex), .cmd_bx(cmd_bx),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_idx(pt_idx), .pt_last(pt_last),
    .busy(busy)
  );

  typedef struct {
    logic [1:0]        sh;
    logic [3:0]        cd;
    int                a, c, ex, bx;
    int                n;
    logic [7:0][9:0]   xs;
    logic [7:0][9:0]   ys;
  } vec_t;

  vec_t tv[4];

  task automatic chk(input string nm, input bit ok, input longint act, input longint expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Reference: wrap modulo 2^N, or clamp to [0,lim] in the clipping build.
  function automatic int fit(input longint v, input longint lim);
`ifdef SHAPE_STREAM_CLIP_EN
    if (v < 0) return 0;
    if (v > lim) return int'(lim);
    return int'(v);
`else
    longint m;
    m = longint'(1) << N;
    if (lim < 0) return 0;
    return int'(((v % m) + m) % m);
`endif
  endfunction

  // Reference point list for one command, computed in closed form.
  function automatic void model(input int sh, input int cd, input int a, input int c,
                                input int e, input int b);
    int n;
    ex_x.delete();
    ex_y.delete();
    if (sh < 2) n = (cd == 5) ? NPTS : 1;
    else        n = (sh == 2) ? 8 : 4;
    for (int i = 0; i < n; i++) begin
      longint x, y, d1, d2, s;
      s = longint'(a) + longint'(i) * longint'(b);
      if (sh == 0) begin
        x = s; y = longint'(c) * s + e;
      end else if (sh == 1) begin
        y = s; x = longint'(c) * s + e;
      end else begin
        d1 = (i >= 4) ? b : c;
        d2 = (i >= 4) ? c : b;
        x = (i % 2 == 1) ? a - d1 : a + d1;
        y = ((i / 2) % 2 == 1) ? e - d2 : e + d2;
      end
      ex_x.push_back(fit(x, XMAX));
      ex_y.push_back(fit(y, YMAX));
    end
  endfunction

  task automatic beat_chk(input int k, input int n);
    checks++;
    if (!(pt_valid === 1'b1 && pt_x === 10'(ex_x[k]) && pt_y === 10'(ex_y[k]) &&
          pt_idx === 3'(k) && pt_last === (k == n - 1) && cmd_ready === 1'b0 && busy === 1'b1)) begin
      errors++;
      $display("FAIL beat%0d: got v=%0d x=%0d y=%0d idx=%0d last=%0d crdy=%0d busy=%0d; want v=1 x=%0d y=%0d idx=%0d last=%0d crdy=0 busy=1",
               k, pt_valid, pt_x, pt_y, pt_idx, pt_last, cmd_ready, busy,
               ex_x[k], ex_y[k], k, (k == n - 1));
    end
  endtask

  task automatic idle_chk(input string nm);
    chk(nm, pt_valid === 1'b0 && busy === 1'b0 && cmd_ready === 1'b1 && pt_x === 10'd0 &&
            pt_y === 10'd0 && pt_idx === 3'd0 && pt_last === 1'b0,
        {pt_valid, busy, cmd_ready, pt_last, pt_idx, pt_x, pt_y}, {4'b0010, 23'd0});
  endtask

  // Issue one command, then consume all beats against ex_x/ex_y.
  task automatic drive_cmd(input logic [1:0] sh, input logic [3:0] cd, input int a, input int c,
                           input int e, input int b, input bit rnd);
    int k, cyc, n;
    bit fired;
    n = ex_x.size();
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("cmd_ready_wait", cmd_ready === 1'b1, cmd_ready, 1);
    cmd_shape = sh; cmd_code = cd;
    cmd_a = 10'(a); cmd_c = 10'(c); cmd_ex = 10'(e); cmd_bx = 10'(b);
    cmd_valid = 1'b1;
    pt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a = 10'($urandom); cmd_c = 10'($urandom);
    k = 0; cyc = 0;
    while (k < n && cyc < 400) begin
      beat_chk(k, n);
      fired = pt_ready;
      @(posedge clk); #1;
      if (fired) k++;
      pt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    chk("beat_timeout", k == n, k, n);
    idle_chk("post_cmd_idle");
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; pt_ready = 1'b0;
    cmd_shape = 2'd0; cmd_code = 4'd0;
    cmd_a = 10'd0; cmd_c = 10'd0; cmd_ex = 10'd0; cmd_bx = 10'd0;
    #1;
    chk("reset_state", pt_valid === 1'b0 && busy === 1'b0 && cmd_ready === 1'b0 &&
        pt_x === 10'd0 && pt_y === 10'd0 && pt_idx === 3'd0 && pt_last === 1'b0,
        {pt_valid, busy, cmd_ready, pt_last}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; #1;
    idle_chk("idle_after_reset");

    // Directed vectors with constant expectations.
    tv[0] = '{sh: 2'd0, cd: 4'b0101, a: 10, c: 2, ex: 5, bx: 3, n: 8,
              xs: {10'd31, 10'd28, 10'd25, 10'd22, 10'd19, 10'd16, 10'd13, 10'd10},
              ys: {10'd67, 10'd61, 10'd55, 10'd49, 10'd43, 10'd37, 10'd31, 10'd25}};
    tv[1] = '{sh: 2'd1, cd: 4'b0000, a: 4, c: 3, ex: 1, bx: 7, n: 1,
              xs: {70'd0, 10'd13}, ys: {70'd0, 10'd4}};
    tv[2] = '{sh: 2'd2, cd: 4'b0000, a: 100, c: 30, ex: 200, bx: 10, n: 8,
              xs: {10'd90, 10'd110, 10'd90, 10'd110, 10'd70, 10'd130, 10'd70, 10'd130},
              ys: {10'd170, 10'd170, 10'd230, 10'd230, 10'd190, 10'd190, 10'd210, 10'd210}};
`ifdef SHAPE_STREAM_CLIP_EN
    tv[3] = '{sh: 2'd0, cd: 4'b0101, a: 1000, c: 1, ex: 0, bx: 20, n: 8,
              xs: {8{10'd639}}, ys: {8{10'd479}}};
`else
    tv[3] = '{sh: 2'd0, cd: 4'b0101, a: 1000, c: 1, ex: 0, bx: 20, n: 8,
              xs: {10'd116, 10'd96, 10'd76, 10'd56, 10'd36, 10'd16, 10'd1020, 10'd1000},
              ys: {10'd116, 10'd96, 10'd76, 10'd56, 10'd36, 10'd16, 10'd1020, 10'd1000}};
`endif
    for (int v = 0; v < 4; v++) begin
      ex_x.delete(); ex_y.delete();
      for (int i = 0; i < tv[v].n; i++) begin
        ex_x.push_back(int'(tv[v].xs[i]));
        ex_y.push_back(int'(tv[v].ys[i]));
      end
      drive_cmd(tv[v].sh, tv[v].cd, tv[v].a, tv[v].c, tv[v].ex, tv[v].bx, 1'b0);
    end

    // ELLIPSE with a 3-cycle stall at idx 1 and a competing command offered.
    cmd_shape = 2'd3; cmd_code = 4'd0;
    cmd_a = 10'd100; cmd_c = 10'd30; cmd_ex = 10'd200; cmd_bx = 10'd10;
    cmd_valid = 1'b1; pt_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("ell_beat0", pt_valid === 1'b1 && pt_x === 10'd130 && pt_y === 10'd210 && pt_idx === 3'd0,
        {pt_x, pt_y}, {10'd130, 10'd210});
    @(posedge clk); #1;
    pt_ready = 1'b0;
    cmd_valid = 1'b1; cmd_shape = 2'd0; cmd_code = 4'b0101;
    cmd_a = 10'd3; cmd_c = 10'd9; cmd_ex = 10'd8; cmd_bx = 10'd1;
    for (int s = 0; s < 4; s++) begin
      chk("ell_stall", pt_valid === 1'b1 && pt_x === 10'd70 && pt_y === 10'd210 &&
          pt_idx === 3'd1 && pt_last === 1'b0 && cmd_ready === 1'b0 && busy === 1'b1,
          {pt_idx, pt_x, pt_y}, {3'd1, 10'd70, 10'd210});
      if (s < 3) begin
        @(posedge clk); #1;
      end
    end
    cmd_valid = 1'b0; pt_ready = 1'b1;
    @(posedge clk); #1;
    chk("ell_beat2", pt_x === 10'd130 && pt_y === 10'd190 && pt_idx === 3'd2 && pt_last === 1'b0,
        {pt_idx, pt_x, pt_y}, {3'd2, 10'd130, 10'd190});
    @(posedge clk); #1;
    chk("ell_beat3", pt_x === 10'd70 && pt_y === 10'd190 && pt_idx === 3'd3 && pt_last === 1'b1,
        {pt_last, pt_idx, pt_x, pt_y}, {1'b1, 3'd3, 10'd70, 10'd190});
    @(posedge clk); #1;
    idle_chk("ell_done");

    // Asynchronous reset in the middle of a CIRCLE burst.
    cmd_shape = 2'd2; cmd_code = 4'd0;
    cmd_a = 10'd100; cmd_c = 10'd30; cmd_ex = 10'd200; cmd_bx = 10'd10;
    cmd_valid = 1'b1; pt_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int w = 0; w < 20 && pt_idx !== 3'd3; w++) begin
      @(posedge clk); #1;
    end
    chk("circ_idx3", pt_idx === 3'd3 && pt_x === 10'd70 && pt_y === 10'd190,
        {pt_idx, pt_x, pt_y}, {3'd3, 10'd70, 10'd190});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", pt_valid === 1'b0 && busy === 1'b0 && cmd_ready === 1'b0 && pt_x === 10'd0 &&
        pt_y === 10'd0 && pt_idx === 3'd0 && pt_last === 1'b0, {pt_valid, busy, pt_idx, pt_x}, 0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    idle_chk("after_async_rst");
    model(0, 5, 10, 2, 5, 3);
    drive_cmd(2'd0, 4'b0101, 10, 2, 5, 3, 1'b0);

    // Randomised commands and backpressure against the reference model.
    for (int r = 0; r < 30; r++) begin
      int sh, cd, a, c, e, b;
      sh = int'($urandom_range(0, 3));
      cd = ($urandom_range(0, 1) == 1) ? 5 : int'($urandom_range(0, 15));
      a = int'($urandom_range(0, 1023)); c = int'($urandom_range(0, 1023));
      e = int'($urandom_range(0, 1023)); b = int'($urandom_range(0, 1023));
      model(sh, cd, a, c, e, b);
      drive_cmd(2'(sh), 4'(cd), a, c, e, b, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
